// File: rtl/shift_add_mult_seq.sv
// Sequential shift/add multiplier that forms one partial product per clock, with valid/ready on both sides.
// Define MULT_SIGNED_EN to treat a/b as two's complement (sign-magnitude internally); otherwise operands are unsigned.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one shift/add step per clock, WIDTH steps total
// DONE  | product presented, held until out_ready

module shift_add_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [2*WIDTH:0]    acc, acc_nxt;
   logic [WIDTH-1:0]    mcand, mcand_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;

   logic [WIDTH:0]      sum;
   logic [2*WIDTH:0]    acc_step;
   logic [2*WIDTH:0]    acc_final;
   logic [WIDTH-1:0]    a_load;
   logic [WIDTH-1:0]    b_load;
   logic                last_step;

`ifdef MULT_SIGNED_EN
   logic                neg, neg_nxt;

   // Magnitude of -2^(W-1) is 2^(W-1), which still fits in WIDTH unsigned bits.
   assign a_load    = a[WIDTH-1] ? (~a + 1'b1) : a;
   assign b_load    = b[WIDTH-1] ? (~b + 1'b1) : b;
   assign acc_final = neg ? {1'b0, (~acc_step[2*WIDTH-1:0] + 1'b1)} : acc_step;
`else
   assign a_load    = a;
   assign b_load    = b;
   assign acc_final = acc_step;
`endif

   // Upper half is always < 2^WIDTH before the add, so the WIDTH+1-bit sum cannot overflow.
   assign sum       = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand}) : acc[2*WIDTH:WIDTH];
   assign acc_step  = {sum, acc[WIDTH-1:0]} >> 1;
   assign last_step = (cnt == CW'(WIDTH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         mcand <= mcand_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef MULT_SIGNED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg <= 1'b0;
      end else begin
         neg <= neg_nxt;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      mcand_nxt = mcand;
      cnt_nxt   = cnt;
`ifdef MULT_SIGNED_EN
      neg_nxt   = neg;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               mcand_nxt = a_load;
               acc_nxt   = {{(WIDTH+1){1'b0}}, b_load};
               cnt_nxt   = '0;
`ifdef MULT_SIGNED_EN
               neg_nxt   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            cnt_nxt = cnt + CW'(1);
            if (last_step) begin
               acc_nxt   = acc_final;
               state_nxt = DONE;
            end else begin
               acc_nxt   = acc_step;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == BUSY) || (state == DONE);
   assign product   = (state == DONE) ? acc[2*WIDTH-1:0] : '0;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Randomized scoreboard bench for shift_add_mult_seq (WIDTH=4); honours MULT_SIGNED_EN in its reference model.

module tb_shift_add_mult_seq;

   localparam int W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   product;
   logic             busy;

   shift_add_mult_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   int compared   = 0;
   int mismatched = 0;

   logic [2*W-1:0]  exp_q[$];
   int unsigned     acc_q[$];

   int              rdy_mode  = 0;   // 0: always ready, 1: random, 2: stall stall_left cycles
   int              stall_left = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      longint p;
`ifdef MULT_SIGNED_EN
      p = longint'($signed(x)) * longint'($signed(y));
`else
      p = longint'(x) * longint'(y);
`endif
      return p[2*W-1:0];
   endfunction

   // Consumer side
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) begin
         out_ready = 1'b1;
      end else if (rdy_mode == 1) begin
         out_ready = 1'($urandom_range(0, 1));
      end else if (out_valid) begin
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
      end else begin
         out_ready = 1'b0;
      end
   end

   // Monitor / scoreboard
   logic            prev_ov    = 1'b0;
   logic            prev_stall = 1'b0;
   logic            prev_hs    = 1'b0;
   logic [2*W-1:0]  prev_prod  = '0;
   int              vcnt       = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            chk("no_overlap", acc_q.size(), 0);
            exp_q.push_back(ref_mul(a, b));
            acc_q.push_back(cyc + 1);
         end
         if (prev_hs) chk("in_ready_after_hs", in_ready, 1);
         if (out_valid) vcnt++;
         else vcnt = 0;
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) chk("spurious_out", out_valid, 0);
            else chk("latency", longint'(cyc) - longint'(acc_q[0]), W);
         end
         if (prev_stall) begin
            chk("hold_product", product, prev_prod);
            chk("hold_valid", out_valid, 1);
         end
         if (out_valid) begin
            chk("in_ready_in_done", in_ready, 0);
            chk("busy_in_done", busy, 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", out_valid, 0);
            end else begin
               chk("product", product, exp_q.pop_front());
               void'(acc_q.pop_front());
            end
            if (rdy_mode == 2) chk("stall_len", vcnt, 6);
         end
         prev_hs    = out_valid && out_ready;
         prev_ov    = out_valid;
         prev_stall = out_valid && !out_ready;
         prev_prod  = product;
      end else begin
         prev_hs    = 1'b0;
         prev_ov    = 1'b0;
         prev_stall = 1'b0;
         vcnt       = 0;
      end
   end

   // Present operands and wait for acceptance; returns just after the acceptance edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
      int n = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = x;
      b = y;
      while (n < 200) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
      end
      if (n >= 200) chk("accept_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      if (!keep) begin
         in_valid = 1'b0;
         a = W'($urandom);
         b = W'($urandom);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_product", product, 0);
      chk("rst_busy", busy, 0);
      #11;
      rst_n = 1'b1;

      rdy_mode = 0;
      issue(4'd15, 4'd15, 1'b0);
      drain();
      issue(4'd0, 4'd13, 1'b0);
      drain();
      issue(4'd13, 4'd0, 1'b0);
      drain();
      issue(4'd7, 4'd9, 1'b1);
      issue(4'd12, 4'd11, 1'b0);
      drain();

      rdy_mode   = 2;
      stall_left = 5;
      issue(4'd6, 4'd5, 1'b0);
      drain();
      rdy_mode = 0;

      // Abort an operation partway through with an asynchronous reset.
      issue(4'd11, 4'd11, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_product", product, 0);
      chk("abort_busy", busy, 0);
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (W + 3) @(posedge clk);
      issue(4'd3, 4'd3, 1'b0);
      drain();

`ifdef MULT_SIGNED_EN
      issue(4'h8, 4'h8, 1'b0);
      issue(4'hD, 4'h5, 1'b0);
      issue(4'h7, 4'hF, 1'b0);
      drain();
`endif

      rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
